// File: rtl/pipe_control_unit_if.sv
// Control/hazard bundle between the 5-stage datapath (master) and pipe_control_unit (slave).
interface pipe_control_unit_if #(
    parameter int REG_AW  = 5,
    parameter int ALU_OPW = 3
);
    logic [5:0]         opcode;
    logic [5:0]         func;
    logic [REG_AW-1:0]  rs_id;
    logic [REG_AW-1:0]  rt_id;
    logic [REG_AW-1:0]  rd_id;
    logic               eq;
    logic               stall;
    logic               flush_ifid;
    logic               pc_src;
    logic [1:0]         jsel;
    logic [ALU_OPW-1:0] ex_alu_op;
    logic               ex_alu_src;
    logic               ex_jal;
    logic               mem_read;
    logic               mem_write;
    logic               wb_reg_write;
    logic               wb_mem_to_reg;
    logic [REG_AW-1:0]  ex_wreg;
    logic [REG_AW-1:0]  mem_wreg;
    logic [REG_AW-1:0]  wb_wreg;
    logic [1:0]         fwd_a;
    logic [1:0]         fwd_b;
    logic               mult_busy;

    modport master (
        output opcode, func, rs_id, rt_id, rd_id, eq,
        input  stall, flush_ifid, pc_src, jsel, ex_alu_op, ex_alu_src, ex_jal,
               mem_read, mem_write, wb_reg_write, wb_mem_to_reg,
               ex_wreg, mem_wreg, wb_wreg, fwd_a, fwd_b, mult_busy
    );

    modport slave (
        input  opcode, func, rs_id, rt_id, rd_id, eq,
        output stall, flush_ifid, pc_src, jsel, ex_alu_op, ex_alu_src, ex_jal,
               mem_read, mem_write, wb_reg_write, wb_mem_to_reg,
               ex_wreg, mem_wreg, wb_wreg, fwd_a, fwd_b, mult_busy
    );
endinterface

// File: rtl/pipe_control_unit.sv
// Decode, ID/EX/MEM/WB control pipeline, stall/flush and EX forwarding for the 5-stage MIPS core.
// Optional multi-cycle multiply interlock is enabled by defining PIPE_CTRL_MULT_EN.
module pipe_control_unit #(
    parameter int REG_AW   = 5,
    parameter int ALU_OPW  = 3
`ifdef PIPE_CTRL_MULT_EN
    ,parameter int MULT_LAT = 4
`endif
) (
    input  logic               clk,
    input  logic               rst_n,
    pipe_control_unit_if.slave bus
);
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_MULT  = 6'b011000;

    typedef struct packed {
        logic [ALU_OPW-1:0] alu_op;
        logic               alu_src;
        logic               jal;
        logic               mem_read;
        logic               mem_write;
        logic               reg_write;
        logic               mem_to_reg;
`ifdef PIPE_CTRL_MULT_EN
        logic               mult;
`endif
        logic [REG_AW-1:0]  wreg;
        logic [REG_AW-1:0]  rs;
        logic [REG_AW-1:0]  rt;
    } ex_ctl_t;

    typedef struct packed {
        logic              mem_read;
        logic              mem_write;
        logic              reg_write;
        logic              mem_to_reg;
        logic [REG_AW-1:0] wreg;
    } mem_ctl_t;

    typedef struct packed {
        logic              reg_write;
        logic              mem_to_reg;
        logic [REG_AW-1:0] wreg;
    } wb_ctl_t;

    function automatic logic [ALU_OPW-1:0] rtype_alu(input logic [5:0] fn);
        logic [ALU_OPW-1:0] op;
        case (fn)
            6'b100000: op = ALU_OPW'(3'b010);
            6'b100010: op = ALU_OPW'(3'b110);
            6'b100100: op = ALU_OPW'(3'b000);
            6'b100101: op = ALU_OPW'(3'b001);
            6'b101010: op = ALU_OPW'(3'b111);
            default:   op = ALU_OPW'(3'b101);
        endcase
        return op;
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] r, input mem_ctl_t m, input wb_ctl_t w);
        logic [1:0] sel;
        if ((r != '0) && m.reg_write && (m.wreg == r)) begin
            sel = 2'b10;
        end else if ((r != '0) && w.reg_write && (w.wreg == r)) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    ex_ctl_t  dec_s, idex_d, idex_q;
    mem_ctl_t exmem_d, exmem_q;
    wb_ctl_t  memwb_d, memwb_q;
    logic       is_br_s, is_jr_s, take_s;
    logic [1:0] jsel_s;
    logic       load_use_s, rs_pend_s, rt_pend_s, haz_s, stall_s, busy_s;

    // ID decode; rs/rt fields carry only the registers the instruction actually reads.
    always_comb begin
        dec_s   = '0;
        is_br_s = 1'b0;
        is_jr_s = 1'b0;
        take_s  = 1'b0;
        jsel_s  = 2'b00;
        case (bus.opcode)
            OP_RTYPE: begin
                case (bus.func)
                    FN_JR: begin
                        dec_s.rs = bus.rs_id;
                        is_jr_s  = 1'b1;
                        take_s   = 1'b1;
                        jsel_s   = 2'b10;
                    end
                    FN_MULT: begin
`ifdef PIPE_CTRL_MULT_EN
                        dec_s.rs   = bus.rs_id;
                        dec_s.rt   = bus.rt_id;
                        dec_s.mult = 1'b1;
`endif
                    end
                    default: begin
                        dec_s.alu_op    = rtype_alu(bus.func);
                        dec_s.reg_write = 1'b1;
                        dec_s.wreg      = bus.rd_id;
                        dec_s.rs        = bus.rs_id;
                        dec_s.rt        = bus.rt_id;
                    end
                endcase
            end
            OP_LW: begin
                dec_s.alu_op     = ALU_OPW'(3'b010);
                dec_s.alu_src    = 1'b1;
                dec_s.mem_read   = 1'b1;
                dec_s.reg_write  = 1'b1;
                dec_s.mem_to_reg = 1'b1;
                dec_s.wreg       = bus.rt_id;
                dec_s.rs         = bus.rs_id;
            end
            OP_SW: begin
                dec_s.alu_op    = ALU_OPW'(3'b010);
                dec_s.alu_src   = 1'b1;
                dec_s.mem_write = 1'b1;
                dec_s.rs        = bus.rs_id;
                dec_s.rt        = bus.rt_id;
            end
            OP_ADDI, OP_SLTI: begin
                dec_s.alu_op    = (bus.opcode == OP_ADDI) ? ALU_OPW'(3'b010) : ALU_OPW'(3'b111);
                dec_s.alu_src   = 1'b1;
                dec_s.reg_write = 1'b1;
                dec_s.wreg      = bus.rt_id;
                dec_s.rs        = bus.rs_id;
            end
            OP_BEQ, OP_BNE: begin
                dec_s.rs = bus.rs_id;
                dec_s.rt = bus.rt_id;
                is_br_s  = 1'b1;
                take_s   = (bus.opcode == OP_BEQ) ? bus.eq : ~bus.eq;
            end
            OP_J: begin
                take_s = 1'b1;
                jsel_s = 2'b01;
            end
            OP_JAL: begin
                dec_s.jal       = 1'b1;
                dec_s.reg_write = 1'b1;
                dec_s.wreg      = {REG_AW{1'b1}};
                take_s          = 1'b1;
                jsel_s          = 2'b01;
            end
            default: dec_s = '0;
        endcase
    end

    // Hazard detection; the ID comparator reads the register file only, so any producer still in EX or MEM blocks it.
    always_comb begin
        load_use_s = idex_q.mem_read && (idex_q.wreg != '0) &&
                     ((idex_q.wreg == dec_s.rs) || (idex_q.wreg == dec_s.rt));
        rs_pend_s  = (bus.rs_id != '0) &&
                     ((idex_q.reg_write && (idex_q.wreg == bus.rs_id)) ||
                      (exmem_q.reg_write && (exmem_q.wreg == bus.rs_id)));
        rt_pend_s  = (bus.rt_id != '0) &&
                     ((idex_q.reg_write && (idex_q.wreg == bus.rt_id)) ||
                      (exmem_q.reg_write && (exmem_q.wreg == bus.rt_id)));
        haz_s      = load_use_s || (is_br_s && (rs_pend_s || rt_pend_s)) || (is_jr_s && rs_pend_s);
        stall_s    = haz_s || busy_s;
    end

    // Next pipeline contents: a busy multiply holds ID/EX and starves EX/MEM, a hazard bubbles ID/EX.
    always_comb begin
        if (busy_s) begin
            idex_d = idex_q;
        end else if (haz_s) begin
            idex_d = '0;
        end else begin
            idex_d = dec_s;
        end
        if (busy_s) begin
            exmem_d = '0;
        end else begin
            exmem_d.mem_read   = idex_q.mem_read;
            exmem_d.mem_write  = idex_q.mem_write;
            exmem_d.reg_write  = idex_q.reg_write;
            exmem_d.mem_to_reg = idex_q.mem_to_reg;
            exmem_d.wreg       = idex_q.wreg;
        end
        memwb_d.reg_write  = exmem_q.reg_write;
        memwb_d.mem_to_reg = exmem_q.mem_to_reg;
        memwb_d.wreg       = exmem_q.wreg;
    end

    // Pipeline registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_q  <= '0;
            exmem_q <= '0;
            memwb_q <= '0;
        end else begin
            idex_q  <= idex_d;
            exmem_q <= exmem_d;
            memwb_q <= memwb_d;
        end
    end

`ifdef PIPE_CTRL_MULT_EN
    localparam int CNT_W = (MULT_LAT > 2) ? $clog2(MULT_LAT) : 1;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             busy_d, busy_q;

    // Multiply occupancy counter, loaded as the mult enters EX.
    always_comb begin
        if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end else if (!haz_s && dec_s.mult) begin
            cnt_d = CNT_W'(MULT_LAT - 1);
        end else begin
            cnt_d = '0;
        end
        busy_d = (cnt_d != '0);
    end

    // Counter and busy flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign busy_s = busy_q;
`else
    assign busy_s = 1'b0;
`endif

    assign bus.stall         = stall_s;
    assign bus.pc_src        = take_s && !stall_s;
    assign bus.flush_ifid    = take_s && !stall_s;
    assign bus.jsel          = jsel_s;
    assign bus.fwd_a         = fwd_sel(idex_q.rs, exmem_q, memwb_q);
    assign bus.fwd_b         = fwd_sel(idex_q.rt, exmem_q, memwb_q);
    assign bus.ex_alu_op     = idex_q.alu_op;
    assign bus.ex_alu_src    = idex_q.alu_src;
    assign bus.ex_jal        = idex_q.jal;
    assign bus.ex_wreg       = idex_q.wreg;
    assign bus.mem_read      = exmem_q.mem_read;
    assign bus.mem_write     = exmem_q.mem_write;
    assign bus.mem_wreg      = exmem_q.wreg;
    assign bus.wb_reg_write  = memwb_q.reg_write;
    assign bus.wb_mem_to_reg = memwb_q.mem_to_reg;
    assign bus.wb_wreg       = memwb_q.wreg;
    assign bus.mult_busy     = busy_s;
endmodule
